// File: rtl/id_ex_stage_reg.sv
// ID/EX pipeline register with load-use hazard detection and multi-cycle multiply hold.
// The D-stage control word, operands and register numbers are registered into E.
// A load-use hazard or an external flush puts a bubble into E.
// A multiply (ALUControl=3) stays in E for MUL_CYCLES cycles.
// Optional feature: define ID_EX_BUBBLE_CNT_EN to add the saturating BubbleCnt output.
module id_ex_stage_reg #(
  parameter int unsigned WIDTH      = 32,
  parameter int unsigned MUL_CYCLES = 4
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  parameter int unsigned CNT_WIDTH  = 16
`endif
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             RegWriteD,
  input  logic             MemtoRegD,
  input  logic             MemWriteD,
  input  logic [2:0]       ALUControlD,
  input  logic             ALUSrcD,
  input  logic             RegDstD,
  input  logic [WIDTH-1:0] RD1D,
  input  logic [WIDTH-1:0] RD2D,
  input  logic [WIDTH-1:0] SignImmD,
  input  logic [4:0]       RsD,
  input  logic [4:0]       RtD,
  input  logic [4:0]       RdD,
  input  logic             FlushExtE,
  output logic             RegWriteE,
  output logic             MemtoRegE,
  output logic             MemWriteE,
  output logic [2:0]       ALUControlE,
  output logic             ALUSrcE,
  output logic             RegDstE,
  output logic [WIDTH-1:0] RD1E,
  output logic [WIDTH-1:0] RD2E,
  output logic [WIDTH-1:0] SignImmE,
  output logic [4:0]       RsE,
  output logic [4:0]       RtE,
  output logic [4:0]       RdE,
  output logic             StallF,
  output logic             StallD,
  output logic             MulBusyE
`ifdef ID_EX_BUBBLE_CNT_EN
  ,
  output logic [CNT_WIDTH-1:0] BubbleCnt
`endif
);

  localparam logic [2:0]  ALU_ADD = 3'd2;
  localparam logic [2:0]  ALU_MUL = 3'd3;
  localparam int unsigned ML_W    = (MUL_CYCLES > 1) ? $clog2(MUL_CYCLES) : 1;

  typedef enum logic {IDLE, MUL_BUSY} state_t;

  state_t            state_q, state_d;
  logic [ML_W-1:0]   mul_left_q, mul_left_d;
  logic              reg_write_q, reg_write_d;
  logic              mem_to_reg_q, mem_to_reg_d;
  logic              mem_write_q, mem_write_d;
  logic [2:0]        alu_ctrl_q, alu_ctrl_d;
  logic              alu_src_q, alu_src_d;
  logic              reg_dst_q, reg_dst_d;
  logic [WIDTH-1:0]  rd1_q, rd1_d;
  logic [WIDTH-1:0]  rd2_q, rd2_d;
  logic [WIDTH-1:0]  imm_q, imm_d;
  logic [4:0]        rs_q, rs_d;
  logic [4:0]        rt_q, rt_d;
  logic [4:0]        rd_q, rd_d;
  logic              lwstall_c;

  // Load in E whose destination is read by the instruction in D.
  assign lwstall_c = mem_to_reg_q & reg_write_q & (rt_q != 5'd0) &
                     ((rt_q == RsD) | (rt_q == RtD));

  assign StallF    = lwstall_c | MulBusyE;
  assign StallD    = lwstall_c | MulBusyE;

  assign RegWriteE   = reg_write_q;
  assign MemtoRegE   = mem_to_reg_q;
  assign MemWriteE   = mem_write_q;
  assign ALUControlE = alu_ctrl_q;
  assign ALUSrcE     = alu_src_q;
  assign RegDstE     = reg_dst_q;
  assign RD1E        = rd1_q;
  assign RD2E        = rd2_q;
  assign SignImmE    = imm_q;
  assign RsE         = rs_q;
  assign RtE         = rt_q;
  assign RdE         = rd_q;
  assign MulBusyE    = (state_q == MUL_BUSY);

  // State register and E-stage pipeline registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= IDLE;
      mul_left_q   <= '0;
      reg_write_q  <= 1'b0;
      mem_to_reg_q <= 1'b0;
      mem_write_q  <= 1'b0;
      alu_ctrl_q   <= ALU_ADD;
      alu_src_q    <= 1'b0;
      reg_dst_q    <= 1'b0;
      rd1_q        <= '0;
      rd2_q        <= '0;
      imm_q        <= '0;
      rs_q         <= '0;
      rt_q         <= '0;
      rd_q         <= '0;
    end else begin
      state_q      <= state_d;
      mul_left_q   <= mul_left_d;
      reg_write_q  <= reg_write_d;
      mem_to_reg_q <= mem_to_reg_d;
      mem_write_q  <= mem_write_d;
      alu_ctrl_q   <= alu_ctrl_d;
      alu_src_q    <= alu_src_d;
      reg_dst_q    <= reg_dst_d;
      rd1_q        <= rd1_d;
      rd2_q        <= rd2_d;
      imm_q        <= imm_d;
      rs_q         <= rs_d;
      rt_q         <= rt_d;
      rd_q         <= rd_d;
    end
  end

  // Next state: hold during multiply, else bubble on hazard/flush, else capture D.
  always_comb begin
    state_d      = state_q;
    mul_left_d   = mul_left_q;
    reg_write_d  = reg_write_q;
    mem_to_reg_d = mem_to_reg_q;
    mem_write_d  = mem_write_q;
    alu_ctrl_d   = alu_ctrl_q;
    alu_src_d    = alu_src_q;
    reg_dst_d    = reg_dst_q;
    rd1_d        = rd1_q;
    rd2_d        = rd2_q;
    imm_d        = imm_q;
    rs_d         = rs_q;
    rt_d         = rt_q;
    rd_d         = rd_q;
    case (state_q)
      MUL_BUSY: begin
        mul_left_d = mul_left_q - ML_W'(1);
        if (mul_left_q == ML_W'(1)) state_d = IDLE;
      end
      default: begin
        if (lwstall_c | FlushExtE) begin
          reg_write_d  = 1'b0;
          mem_to_reg_d = 1'b0;
          mem_write_d  = 1'b0;
          alu_ctrl_d   = ALU_ADD;
          alu_src_d    = 1'b0;
          reg_dst_d    = 1'b0;
          rd1_d        = '0;
          rd2_d        = '0;
          imm_d        = '0;
          rs_d         = '0;
          rt_d         = '0;
          rd_d         = '0;
        end else begin
          reg_write_d  = RegWriteD;
          mem_to_reg_d = MemtoRegD;
          mem_write_d  = MemWriteD;
          alu_ctrl_d   = ALUControlD;
          alu_src_d    = ALUSrcD;
          reg_dst_d    = RegDstD;
          rd1_d        = RD1D;
          rd2_d        = RD2D;
          imm_d        = SignImmD;
          rs_d         = RsD;
          rt_d         = RtD;
          rd_d         = RdD;
          if ((ALUControlD == ALU_MUL) && (MUL_CYCLES > 1)) begin
            state_d    = MUL_BUSY;
            mul_left_d = ML_W'(MUL_CYCLES - 1);
          end
        end
      end
    endcase
  end

`ifdef ID_EX_BUBBLE_CNT_EN
  logic [CNT_WIDTH-1:0] bcnt_q, bcnt_d;
  logic                 bubble_c;

  assign bubble_c  = (state_q == IDLE) & (lwstall_c | FlushExtE);
  assign BubbleCnt = bcnt_q;

  // Saturating count of inserted bubbles.
  always_comb begin
    bcnt_d = bcnt_q;
    if (bubble_c && (bcnt_q != {CNT_WIDTH{1'b1}})) bcnt_d = bcnt_q + CNT_WIDTH'(1);
  end

  // Bubble counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) bcnt_q <= '0;
    else        bcnt_q <= bcnt_d;
  end
`endif

endmodule
